// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch, load and store channels share one req/ack memory port.
// Optional MEM_PORT_ARBITER_TIMEOUT_EN bounds the wait for the memory acknowledge.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int TIMEOUT_CYCLES     = 255,
    parameter int FETCH_STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_fetch_enable,
    input  logic [ADDR_WIDTH-1:0] in_fetch_address,
    output logic                  out_fetch_ready,
    output logic                  out_fetch_valid,
    output logic [DATA_WIDTH-1:0] out_fetch_data,
    input  logic                  in_read_enable,
    input  logic [ADDR_WIDTH-1:0] in_read_address,
    output logic                  out_read_ready,
    output logic                  out_read_valid,
    output logic [DATA_WIDTH-1:0] out_read_data,
    input  logic                  in_write_enable,
    input  logic [ADDR_WIDTH-1:0] in_write_address,
    input  logic [DATA_WIDTH-1:0] in_write_data,
    output logic                  out_write_ready,
    output logic                  out_write_valid,
    output logic                  out_exception_valid,
    output logic [3:0]            out_exception_code,
    output logic                  out_mem_req,
    output logic                  out_mem_we,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_wdata,
    input  logic                  in_mem_ack,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    input  logic                  in_mem_error
);

    localparam int SW = (FETCH_STARVE_LIMIT < 1) ? 1 : $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MEM = 2'd1, ST_RESP = 2'd2} state_e;
    typedef enum logic [1:0] {CH_FETCH = 2'd0, CH_READ = 2'd1, CH_WRITE = 2'd2} chan_e;

    // RISC-V cause: misaligned codes 0/4/6, access faults one above.
    function automatic logic [3:0] exc_code(input chan_e ch, input logic fault);
        logic [3:0] base;
        case (ch)
            CH_FETCH: base = 4'd0;
            CH_READ:  base = 4'd4;
            CH_WRITE: base = 4'd6;
            default:  base = 4'd0;
        endcase
        return base + {3'b000, fault};
    endfunction

    state_e                state_q, state_d;
    chan_e                 chan_q, chan_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic                  misal_q, misal_d;
    logic [SW-1:0]         starve_q, starve_d;

    logic                  grant_fetch_s, grant_read_s, grant_write_s;
    logic                  fetch_first_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  misal_s;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    // Arbitration: write > read > fetch unless fetch has starved long enough.
    always_comb begin
        grant_fetch_s = 1'b0;
        grant_read_s  = 1'b0;
        grant_write_s = 1'b0;
        fetch_first_s = in_fetch_enable && (starve_q >= STARVE_MAX);
        if (reset && (state_q == ST_IDLE)) begin
            if (fetch_first_s) begin
                grant_fetch_s = 1'b1;
            end else if (in_write_enable) begin
                grant_write_s = 1'b1;
            end else if (in_read_enable) begin
                grant_read_s = 1'b1;
            end else begin
                grant_fetch_s = in_fetch_enable;
            end
        end else begin
            grant_fetch_s = 1'b0;
        end
        if (grant_write_s) begin
            sel_addr_s = in_write_address;
        end else if (grant_read_s) begin
            sel_addr_s = in_read_address;
        end else begin
            sel_addr_s = in_fetch_address;
        end
        misal_s = (sel_addr_s[1:0] != 2'b00);
    end

    // Next-state logic for the transaction FSM and its latched context.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        misal_d  = misal_q;
        starve_d = starve_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_fetch_s || grant_read_s || grant_write_s) begin
                    chan_d  = grant_write_s ? CH_WRITE : (grant_read_s ? CH_READ : CH_FETCH);
                    addr_d  = sel_addr_s;
                    wdata_d = grant_write_s ? in_write_data : '0;
                    rdata_d = '0;
                    fault_d = 1'b0;
                    misal_d = misal_s;
                    state_d = misal_s ? ST_RESP : ST_MEM;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
                if (grant_fetch_s) begin
                    starve_d = '0;
                end else if (in_fetch_enable && (grant_read_s || grant_write_s)
                             && (starve_q < STARVE_MAX)) begin
                    starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    starve_d = starve_q;
                end
            end
            ST_MEM: begin
                if (in_mem_ack) begin
                    rdata_d = in_mem_error ? '0 : in_mem_rdata;
                    fault_d = in_mem_error;
                    state_d = ST_RESP;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
                end
`else
                end else begin
                    state_d = ST_MEM;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and context registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            chan_q   <= CH_FETCH;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            misal_q  <= 1'b0;
            starve_q <= '0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            misal_q  <= misal_d;
            starve_q <= starve_d;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    // Outputs decode from registered state; memory/response buses are zero when idle.
    logic mem_s, resp_s;
    assign mem_s  = (state_q == ST_MEM);
    assign resp_s = (state_q == ST_RESP);

    assign out_fetch_ready     = grant_fetch_s;
    assign out_read_ready      = grant_read_s;
    assign out_write_ready     = grant_write_s;
    assign out_mem_req         = mem_s;
    assign out_mem_we          = mem_s && (chan_q == CH_WRITE);
    assign out_mem_addr        = mem_s ? addr_q : '0;
    assign out_mem_wdata       = (mem_s && (chan_q == CH_WRITE)) ? wdata_q : '0;
    assign out_fetch_valid     = resp_s && (chan_q == CH_FETCH);
    assign out_read_valid      = resp_s && (chan_q == CH_READ);
    assign out_write_valid     = resp_s && (chan_q == CH_WRITE);
    assign out_fetch_data      = out_fetch_valid ? rdata_q : '0;
    assign out_read_data       = out_read_valid ? rdata_q : '0;
    assign out_exception_valid = resp_s && (misal_q || fault_q);
    assign out_exception_code  = out_exception_valid ? exc_code(chan_q, fault_q) : 4'd0;

endmodule
